// File: rtl/multi_output_stretch_pkg.sv
// Shared types and helpers for the four-channel LED pulse stretcher.
package multi_output_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } t_stretch_state;

  function automatic int ms_to_cycles(
    input int fclk,
    input int ms
  );
    return fclk / 1000 * ms;
  endfunction

endpackage

// File: rtl/stretch_channel.sv
// One LED channel: IDLE -> HOLD (on) -> GAP (off), with retrigger
// in HOLD and a one-deep pending event queued during GAP.
module stretch_channel
  import multi_output_stretch_pkg::*;
#(
  parameter int C_HOLD = 20,
  parameter int C_GAP  = 10
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_strobe,
  input  logic i_on,
  output logic o_led,
  output logic o_busy
);

  localparam int C_MAX = (C_HOLD > C_GAP) ? C_HOLD : C_GAP;
  localparam int TW    = $clog2(C_MAX + 1);

  localparam logic [TW-1:0] T_SAT    = '1;
  localparam logic [TW-1:0] HOLD_END = TW'(C_HOLD - 1);
  localparam logic [TW-1:0] GAP_END  = TW'(C_GAP - 1);

  t_stretch_state state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           pend_q, pend_d;
  logic           led_q, led_d;
  logic           busy_q, busy_d;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      pend_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    timer_d = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (i_strobe) begin
          state_d = ST_HOLD;
          timer_d = '0;
        end
      end
      ST_HOLD: begin
        if (i_strobe) begin
          timer_d = '0;
        end else if (timer_q == HOLD_END) begin
          state_d = ST_GAP;
          timer_d = '0;
        end
      end
      ST_GAP: begin
        if (timer_q == GAP_END) begin
          state_d = (pend_q || i_strobe) ? ST_HOLD : ST_IDLE;
          timer_d = '0;
          pend_d  = 1'b0;
        end else if (i_strobe) begin
          pend_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // Outputs decode the next state so they change on the same edge.
  always_comb begin
    led_d  = (state_d == ST_HOLD) && i_on;
    busy_d = (state_d != ST_IDLE);
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;

endmodule

// File: rtl/multi_output_stretch.sv
// Four-channel LED pulse stretcher; MULTI_OUTPUT_STRETCH_PWM_EN adds
// a shared PWM dimmer applied while a channel is in HOLD.
module multi_output_stretch
  import multi_output_stretch_pkg::*;
#(
  parameter int FCLK    = 20000000,
  parameter int HOLD_MS = 50,
  parameter int GAP_MS  = 20
) (
  input  logic       i_clk_mhz,
  input  logic       i_rstn_mhz,
  input  logic [3:0] i_pulses,
  input  logic [3:0] i_duty,
  output logic [3:0] eo_leds,
  output logic [3:0] o_busy
);

  localparam int C_HOLD = ms_to_cycles(FCLK, HOLD_MS);
  localparam int C_GAP  = ms_to_cycles(FCLK, GAP_MS);

  logic pwm_on;

`ifdef MULTI_OUTPUT_STRETCH_PWM_EN
  logic [3:0] pwm_q, pwm_d;

  always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
    if (!i_rstn_mhz) pwm_q <= '0;
    else             pwm_q <= pwm_d;
  end

  always_comb begin
    pwm_d  = pwm_q + 4'd1;
    pwm_on = (pwm_q < i_duty);
  end
`else
  logic unused_duty;

  assign unused_duty = ^i_duty;
  assign pwm_on      = 1'b1;
`endif

  for (genvar k = 0; k < 4; k++) begin : g_ch
    stretch_channel #(
      .C_HOLD (C_HOLD),
      .C_GAP  (C_GAP)
    ) u_ch (
      .i_clk    (i_clk_mhz),
      .i_rstn   (i_rstn_mhz),
      .i_strobe (i_pulses[k]),
      .i_on     (pwm_on),
      .o_led    (eo_leds[k]),
      .o_busy   (o_busy[k])
    );
  end

endmodule

// File: tb/tb_multi_output_stretch.sv
// Bench for multi_output_stretch at c_hold=20, c_gap=10; also covers
// MULTI_OUTPUT_STRETCH_PWM_EN when that macro is defined.
module tb_multi_output_stretch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pulses = 4'b0;
  logic [3:0] duty = 4'd0;
  logic [3:0] leds;
  logic [3:0] busy;
  logic [3:0] pwm_m;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] led;
    logic [3:0] busy;
  } exp_t;

  typedef struct {
    string      name;
    logic [3:0] mask;
    int         t2;
    int         hi_end;
    int         hi2_lo;
    int         hi2_hi;
    int         busy_end;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  multi_output_stretch #(
    .FCLK    (10000),
    .HOLD_MS (2),
    .GAP_MS  (1)
  ) dut (
    .i_clk_mhz  (clk),
    .i_rstn_mhz (rst_n),
    .i_pulses   (pulses),
    .i_duty     (duty),
    .eo_leds    (leds),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_m <= 4'd0;
    else        pwm_m <= pwm_m + 4'd1;
  end

  function automatic logic [3:0] gate();
`ifdef MULTI_OUTPUT_STRETCH_PWM_EN
    return (pwm_m < duty) ? 4'hf : 4'h0;
`else
    return 4'hf;
`endif
  endfunction

  task automatic check(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] p, input logic [3:0] eled,
                      input logic [3:0] ebusy, input string nm);
    exp_t e;
    pulses = p;
    e.led  = eled & gate();
    e.busy = ebusy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      check({nm, " led"}, leds, e.led);
      check({nm, " busy"}, busy, e.busy);
    end
  endtask

  task automatic run_vec(input vec_t v);
    for (int t = 0; t <= v.busy_end + 2; t++) begin
      int  tn;
      logic hi;
      logic bz;
      tn = t + 1;
      hi = (tn <= v.hi_end) || (tn >= v.hi2_lo && tn <= v.hi2_hi);
      bz = (tn <= v.busy_end);
      step((t == 0 || t == v.t2) ? v.mask : 4'b0,
           hi ? v.mask : 4'b0, bz ? v.mask : 4'b0, v.name);
    end
  endtask

  initial begin
    vecs[0] = '{"single",   4'b0001, -1, 20,  0, -1, 30};
    vecs[1] = '{"retrig",   4'b0010, 15, 35,  0, -1, 45};
    vecs[2] = '{"gapq",     4'b0100, 25, 20, 31, 50, 60};
    vecs[3] = '{"simul",    4'b1011, -1, 20,  0, -1, 30};
    vecs[4] = '{"holdlast", 4'b1000, 20, 40,  0, -1, 50};
    vecs[5] = '{"gaplast",  4'b0001, 30, 20, 31, 50, 60};

`ifdef MULTI_OUTPUT_STRETCH_PWM_EN
    duty = 4'd4;
`endif
    rst_n  = 1'b0;
    pulses = 4'b1111;
    #1;
    check("rst led t0", leds, 4'b0);
    check("rst busy t0", busy, 4'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst led", leds, 4'b0);
      check("rst busy", busy, 4'b0);
    end
    rst_n  = 1'b1;
    pulses = 4'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    for (int t = 0; t < 82; t++) begin
      int tn;
      tn = t + 1;
      step((t < 50) ? 4'b0001 : 4'b0,
           (tn <= 69) ? 4'b0001 : 4'b0,
           (tn <= 79) ? 4'b0001 : 4'b0, "held");
    end

    for (int t = 0; t < 8; t++)
      step((t == 0) ? 4'b1000 : 4'b0, 4'b1000, 4'b1000, "pre-arst");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst led", leds, 4'b0);
    check("arst busy", busy, 4'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 40; t++)
      step(4'b0, 4'b0, 4'b0, "post-arst");

`ifdef MULTI_OUTPUT_STRETCH_PWM_EN
    duty = 4'd0;
    run_vec(vecs[0]);
    duty = 4'd15;
    run_vec(vecs[3]);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
